// File: rtl/sopc_data_bus_if.sv
// Data-side bus bundle between the CPU data port and the
// slave channels of the SOPC interconnect.
interface sopc_data_bus_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic                         m_ce;
  logic                         m_we;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W/8-1:0]          m_sel;
  logic [DATA_W-1:0]            m_wdata;
  logic [DATA_W-1:0]            m_rdata;
  logic                         m_stall;
  logic [NUM_SLAVES-1:0]        s_ce;
  logic                         s_we;
  logic [ADDR_W-1:0]            s_addr;
  logic [DATA_W/8-1:0]          s_sel;
  logic [DATA_W-1:0]            s_wdata;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]        s_ack;
  logic                         bus_err;
  logic [ADDR_W-1:0]            err_addr;

  modport master (
    output m_ce, m_we, m_addr, m_sel, m_wdata,
    input  m_rdata, m_stall
  );

  modport slave (
    input  m_ce, m_we, m_addr, m_sel, m_wdata,
    input  s_rdata, s_ack,
    output m_rdata, m_stall,
    output s_ce, s_we, s_addr, s_sel, s_wdata,
    output bus_err, err_addr
  );
endinterface

// File: rtl/sopc_data_bus.sv
// Data-side interconnect: address decode, req/ack handshake,
// CPU stall generation and timeout/unmapped error reporting.
module sopc_data_bus #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEC_BITS   = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic            clk,
  input  logic            rst,
  sopc_data_bus_if.slave  bus
);
  localparam int SW = DATA_W / 8;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DEC_BITS-1:0]   w_idx;
  logic                  w_map;
  logic [NUM_SLAVES-1:0] w_hot;
  logic [DATA_W-1:0]     w_rd;
  logic                  w_ack;
  logic                  w_tmo;

  logic [DEC_BITS-1:0]   r_idx;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [SW-1:0]         r_sel;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [ADDR_W-1:0]     r_eaddr;

  always_comb begin
    w_idx = bus.m_addr[ADDR_W-1 -: DEC_BITS];
    w_map = {1'b0, w_idx} <
            (DEC_BITS+1)'(NUM_SLAVES);
    w_hot = '0;
    w_rd  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_hot[i] = (r_idx == DEC_BITS'(i));
      if (w_hot[i])
        w_rd = w_rd | bus.s_rdata[i*DATA_W +: DATA_W];
    end
    w_ack = |(bus.s_ack & w_hot);
    w_tmo = (r_cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (bus.m_ce)
          w_next = w_map ? BUSY : DONE;
      end
      BUSY: begin
        if (w_ack || w_tmo)
          w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ce     = (r_state == BUSY) ? w_hot : '0;
    bus.m_stall  = bus.m_ce && (r_state != DONE);
    bus.s_we     = r_we;
    bus.s_addr   = r_addr;
    bus.s_sel    = r_sel;
    bus.s_wdata  = r_wdata;
    bus.m_rdata  = r_rdata;
    bus.bus_err  = r_err;
    bus.err_addr = r_eaddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_sel   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_eaddr <= '0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.m_ce && w_map) begin
            r_idx   <= w_idx;
            r_cnt   <= '0;
            r_we    <= bus.m_we;
            r_addr  <= bus.m_addr;
            r_sel   <= bus.m_sel;
            r_wdata <= bus.m_wdata;
          end else if (bus.m_ce) begin
            r_eaddr <= bus.m_addr;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
        end
        BUSY: begin
          // ack wins over a timeout landing in the same cycle
          if (w_ack) begin
            if (!r_we) r_rdata <= w_rd;
          end else if (w_tmo) begin
            r_eaddr <= r_addr;
            r_err   <= 1'b1;
            r_rdata <= '0;
          end
          if (r_cnt != CW'(TIMEOUT))
            r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sopc_data_bus.sv
// Directed bench for sopc_data_bus with a cycle-level
// transaction model and hand-computed literal checks.
module tb_sopc_data_bus;
  localparam int NS = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sopc_data_bus_if #(
    .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)
  ) bus ();

  sopc_data_bus #(
    .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
    .DEC_BITS(4), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // slave i acks in its BUSY cycle dly[i] (0 = never)
  int          dly[NS];
  logic [31:0] rtab[NS];
  logic [NS-1:0] stray;
  int          scnt[NS];

  initial begin
    bus.s_ack   = '0;
    bus.s_rdata = '0;
    for (int i = 0; i < NS; i++) scnt[i] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < NS; i++) begin
        if (bus.s_ce[i]) scnt[i]++;
        else scnt[i] = 0;
        bus.s_ack[i] = stray[i] ||
          (dly[i] != 0 && scnt[i] == dly[i]);
        bus.s_rdata[i*32 +: 32] = rtab[i];
      end
    end
  end

  // transaction model: busy_n = BUSY cycle number, fin = DONE
  int          busy_n = 0;
  bit          fin    = 0;
  int          midx   = 0;
  logic        q_we   = 0;
  logic [31:0] q_addr = 0;
  logic [3:0]  q_sel  = 0;
  logic [31:0] q_wd   = 0;
  logic [31:0] e_rd   = 0;
  logic        e_err  = 0;
  logic [31:0] e_ea   = 0;

  always @(negedge clk) begin
    logic [3:0] hot;
    hot = (busy_n > 0) ? 4'(1 << midx) : 4'd0;
    chk("m_stall", 32'(bus.m_stall),
        32'(bus.m_ce && !fin));
    chk("s_ce", 32'(bus.s_ce), 32'(hot));
    chk("s_we", 32'(bus.s_we), 32'(q_we));
    chk("s_addr", bus.s_addr, q_addr);
    chk("s_sel", 32'(bus.s_sel), 32'(q_sel));
    chk("s_wdata", bus.s_wdata, q_wd);
    chk("m_rdata", bus.m_rdata, e_rd);
    chk("bus_err", 32'(bus.bus_err), 32'(e_err));
    chk("err_addr", bus.err_addr, e_ea);
    if (rst) begin
      busy_n = 0; fin = 0;
      q_we = 0; q_addr = 0; q_sel = 0; q_wd = 0;
      e_rd = 0; e_err = 0; e_ea = 0;
    end else begin
      e_err = 0;
      if (fin) begin
        fin = 0;
      end else if (busy_n > 0) begin
        if (bus.s_ack[midx]) begin
          fin = 1; busy_n = 0;
          if (!q_we) e_rd = bus.s_rdata[midx*32 +: 32];
        end else if (busy_n == TO) begin
          fin = 1; busy_n = 0;
          e_err = 1; e_ea = q_addr; e_rd = 0;
        end else begin
          busy_n++;
        end
      end else if (bus.m_ce) begin
        midx = int'(bus.m_addr[31:28]);
        if (midx < NS) begin
          busy_n = 1;
          q_we = bus.m_we; q_addr = bus.m_addr;
          q_sel = bus.m_sel; q_wd = bus.m_wdata;
        end else begin
          fin = 1; e_err = 1;
          e_ea = bus.m_addr; e_rd = 0;
        end
      end
    end
  end

  int          st;
  int          sn;
  logic [3:0]  so;
  logic [31:0] rd;
  logic        er;
  logic [31:0] ea;

  task automatic xfer(input logic we,
                      input logic [31:0] a,
                      input logic [3:0] sel,
                      input logic [31:0] wd,
                      output int stalls,
                      output int sce_n,
                      output logic [3:0] sce_or,
                      output logic [31:0] rdat,
                      output logic err,
                      output logic [31:0] eadr);
    bit ok;
    ok = 0;
    bus.m_ce = 1; bus.m_we = we; bus.m_addr = a;
    bus.m_sel = sel; bus.m_wdata = wd;
    stalls = 0; sce_n = 0; sce_or = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      sce_or = sce_or | bus.s_ce;
      if (bus.s_ce != '0) sce_n++;
      if (!bus.m_stall) begin
        ok = 1;
        break;
      end
      stalls++;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL xfer_bound: no DONE within 40 cycles");
    end
    rdat = bus.m_rdata; err = bus.bus_err;
    eadr = bus.err_addr;
    @(posedge clk);
    #1;
    bus.m_ce = 0;
  endtask

  initial begin
    rst = 1; stray = '0;
    bus.m_ce = 0; bus.m_we = 0; bus.m_addr = '0;
    bus.m_sel = '0; bus.m_wdata = '0;
    for (int i = 0; i < NS; i++) begin
      dly[i] = 0; rtab[i] = 32'hC0DE_0000 + i;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ce", 32'(bus.s_ce), 0);
    chk("rst_rdata", bus.m_rdata, 0);
    chk("rst_err", 32'(bus.bus_err), 0);
    chk("rst_eaddr", bus.err_addr, 0);
    chk("rst_stall", 32'(bus.m_stall), 0);
    @(posedge clk); #1; rst = 0;

    dly[1] = 1; rtab[1] = 32'hDEAD_BEEF;
    xfer(0, 32'h1000_0010, 4'hF, 0, st, sn, so, rd, er, ea);
    chk("zw_stall", st, 2);
    chk("zw_rdata", rd, 32'hDEAD_BEEF);
    chk("zw_sce", 32'(so), 32'h2);
    chk("zw_sce_n", sn, 1);

    dly[1] = 0;
    bus.m_ce = 1; bus.m_we = 0; bus.m_addr = 32'h1000_0010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; bus.m_ce = 0;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("mr_s_ce", 32'(bus.s_ce), 0);
    chk("mr_rdata", bus.m_rdata, 0);
    chk("mr_err", 32'(bus.bus_err), 0);
    chk("mr_stall", 32'(bus.m_stall), 0);
    @(posedge clk); #1;
    dly[1] = 3; rtab[1] = 32'h0BAD_F00D;
    xfer(0, 32'h1000_0020, 4'hF, 0, st, sn, so, rd, er, ea);
    chk("mr_new_stall", st, 4);
    chk("mr_new_rdata", rd, 32'h0BAD_F00D);

    dly[2] = 5;
    xfer(1, 32'h2000_0004, 4'b0011, 32'h1234_5678,
         st, sn, so, rd, er, ea);
    chk("wr_stall", st, 6);
    chk("wr_rdata", rd, 32'h0BAD_F00D);
    chk("wr_err", 32'(er), 0);
    chk("wr_sce_n", sn, 5);
    chk("wr_hold_addr", bus.s_addr, 32'h2000_0004);
    chk("wr_hold_sel", 32'(bus.s_sel), 32'h3);
    chk("wr_hold_wd", bus.s_wdata, 32'h1234_5678);

    xfer(0, 32'hF000_0000, 4'hF, 0, st, sn, so, rd, er, ea);
    chk("um_stall", st, 1);
    chk("um_err", 32'(er), 1);
    chk("um_eaddr", ea, 32'hF000_0000);
    chk("um_rdata", rd, 0);
    chk("um_sce", 32'(so), 0);
    @(negedge clk);
    chk("um_err_pulse", 32'(bus.bus_err), 0);
    @(posedge clk); #1;

    dly[3] = TO; rtab[3] = 32'hA5A5_0003;
    xfer(0, 32'h3000_0008, 4'hF, 0, st, sn, so, rd, er, ea);
    chk("tb16_stall", st, 17);
    chk("tb16_err", 32'(er), 0);
    chk("tb16_rdata", rd, 32'hA5A5_0003);
    chk("tb16_eaddr", ea, 32'hF000_0000);

    dly[0] = 0;
    xfer(0, 32'h0000_0100, 4'hF, 0, st, sn, so, rd, er, ea);
    chk("to_stall", st, 17);
    chk("to_err", 32'(er), 1);
    chk("to_eaddr", ea, 32'h0000_0100);
    chk("to_rdata", rd, 0);
    chk("to_sce_n", sn, 16);

    dly[3] = 2; rtab[3] = 32'h3333_3333;
    rtab[0] = 32'h0000_0BAD;
    stray = 4'b0001;
    xfer(0, 32'h3000_0000, 4'hF, 0, st, sn, so, rd, er, ea);
    stray = '0;
    chk("sa_stall", st, 3);
    chk("sa_rdata", rd, 32'h3333_3333);
    dly[1] = 1; rtab[1] = 32'h5555_AAAA;
    xfer(0, 32'h1000_0000, 4'hF, 0, st, sn, so, rd, er, ea);
    chk("b2b_stall", st, 2);
    chk("b2b_rdata", rd, 32'h5555_AAAA);
    chk("b2b_err", 32'(er), 0);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
